// File: rtl/tick_slot_arbiter.sv
// Round-robin arbiter sharing one resource among N_REQ requesters; each grant
// is bounded to SLOT_TICKS prescaler ticks and followed by a one-cycle dead gap.
module tick_slot_arbiter #(
  parameter int N_REQ      = 4,
  parameter int SLOT_TICKS = 8,
  localparam int ID_W      = $clog2(N_REQ),
  localparam int CNT_W     = $clog2(SLOT_TICKS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_e;

  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] SLOT_LOAD = CNT_W'(SLOT_TICKS);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(1);

  state_e             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [ID_W-1:0]    gnt_id_q;
  logic               busy_q;
  logic               timeout_q;
  logic [ID_W-1:0]    ptr_q;
  logic [CNT_W-1:0]   slot_cnt_q;

  logic [2*N_REQ-1:0] req_rot;
  logic               win_found_d;
  logic [ID_W-1:0]    win_off_d;
  logic [ID_W:0]      win_sum_d;
  logic [ID_W-1:0]    win_id_d;
  logic [N_REQ-1:0]   win_vec_d;
  logic [ID_W-1:0]    next_ptr_d;

  // Rotate requests so bit 0 is the pointer position; the first set bit is the winner.
  always_comb begin
    req_rot     = {req, req} >> ptr_q;
    win_found_d = 1'b0;
    win_off_d   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found_d && req_rot[i]) begin
        win_found_d = 1'b1;
        win_off_d   = ID_W'(i);
      end
    end
    win_sum_d = {1'b0, ptr_q} + {1'b0, win_off_d};
    if (win_sum_d >= (ID_W+1)'(N_REQ)) begin
      win_sum_d = win_sum_d - (ID_W+1)'(N_REQ);
    end
    win_id_d   = win_sum_d[ID_W-1:0];
    win_vec_d  = N_REQ'(1) << win_id_d;
    next_ptr_d = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      slot_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, GAP: begin
          if (win_found_d) begin
            state_q    <= GRANT;
            gnt_q      <= win_vec_d;
            gnt_id_q   <= win_id_d;
            busy_q     <= 1'b1;
            slot_cnt_q <= SLOT_LOAD;
          end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        GRANT: begin
          // Release outranks expiry so a voluntary drop never reports a timeout.
          if (!req[gnt_id_q]) begin
            state_q    <= GAP;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= next_ptr_d;
            slot_cnt_q <= '0;
          end else if (tick && (slot_cnt_q == SLOT_LAST)) begin
            state_q    <= GAP;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b1;
            ptr_q      <= next_ptr_d;
            slot_cnt_q <= '0;
          end else if (tick) begin
            slot_cnt_q <= slot_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          gnt_q      <= '0;
          busy_q     <= 1'b0;
          slot_cnt_q <= '0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_tick_slot_arbiter.sv
// Bench for tick_slot_arbiter (N_REQ=4, SLOT_TICKS=3): directed vectors, a
// behavioural owner/ticks-left model checked every cycle, and literal pins.
module tb_tick_slot_arbiter;

  localparam int N = 4;
  localparam int SLOT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         tick = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;
  logic [1:0]   state_o;

  tick_slot_arbiter #(.N_REQ(N), .SLOT_TICKS(SLOT)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout),
    .state_o(state_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner = -1 when nobody holds the resource; gap cycles fall out naturally
  // because a freed resource is only re-arbitrated on the following edge.
  int m_owner = -1;
  int m_left = 0;
  int m_ptr = 0;
  int m_last = 0;
  bit m_to = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_left = 0; m_ptr = 0; m_last = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end else if (tick && m_left == 1) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
          m_to = 1'b1;
        end else if (tick) begin
          m_left = m_left - 1;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
        if (m_owner >= 0) begin
          m_last = m_owner;
          m_left = SLOT;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("model_gnt", gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("model_gnt_id", gnt_id, m_last);
      chk("model_busy", busy, m_owner >= 0);
      chk("model_timeout", timeout, m_to);
    end
  end

  // ---------------- driver tasks ----------------
  bit auto_tick = 1'b1;
  int phase = 0;

  // Drive one cycle: inputs change on negedge, return 1 unit after the sampling edge.
  task automatic cyc(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    tick = auto_tick && (phase == 3);
    phase = (phase + 1) % 4;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_t(input logic [N-1:0] r, input logic t);
    @(negedge clk);
    req = r;
    tick = t;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] prev_gnt;
    int           grants;
    int           tos;
    bit           seen;

    // 1. reset then quiet bus
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_gnt", gnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_state", state_o, 0);
    repeat (20) cyc(4'b0000);
    chk("quiet_gnt", gnt, 0);

    // 2. single requester, 1-cycle latency, release, pointer moves to 3
    cyc(4'b0100);
    chk("t2_gnt", gnt, 4'b0100);
    chk("t2_gnt_id", gnt_id, 2);
    chk("t2_busy", busy, 1);
    repeat (4) cyc(4'b0100);
    cyc(4'b0000);
    chk("t2_release_gnt", gnt, 0);
    chk("t2_release_to", timeout, 0);
    chk("t2_hold_id", gnt_id, 2);
    cyc(4'b0000);
    cyc(4'b1001);
    chk("t2_ptr3_winner", gnt_id, 3);
    cyc(4'b0000);
    cyc(4'b0000);

    // 3. everyone requests: round robin 0,1,2,3,0 with timeouts between
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    prev_gnt = '0; grants = 0; tos = 0;
    for (int c = 0; c < 400 && grants < 5; c++) begin
      cyc(4'b1111);
      if (timeout) tos++;
      if (gnt != 0 && prev_gnt != 0 && gnt != prev_gnt) chk("t3_no_gap", prev_gnt, 0);
      if (gnt != 0 && prev_gnt == 0) begin
        chk("t3_order", gnt_id, exp_q.pop_front());
        grants++;
      end
      prev_gnt = gnt;
    end
    chk("t3_grant_count", grants, 5);
    chk("t3_timeouts", tos, 4);
    cyc(4'b0000);
    cyc(4'b0000);

    // 4. sole requester expires then is regranted after one gap cycle
    seen = 1'b0;
    cyc(4'b0010);
    chk("t4_gnt", gnt, 4'b0010);
    for (int c = 0; c < 40 && !seen; c++) begin
      cyc(4'b0010);
      if (timeout) seen = 1'b1;
    end
    chk("t4_timeout_seen", seen, 1);
    chk("t4_gap_gnt", gnt, 0);
    chk("t4_gap_busy", busy, 0);
    cyc(4'b0010);
    chk("t4_regrant", gnt, 4'b0010);
    chk("t4_to_pulse", timeout, 0);
    cyc(4'b0000);
    cyc(4'b0000);

    // 5. release on the final tick beats expiry; then a true expiry
    auto_tick = 1'b0;
    cyc_t(4'b0000, 1'b1);
    cyc_t(4'b0000, 1'b1);
    cyc_t(4'b0001, 1'b0);
    chk("t5_gnt", gnt, 4'b0001);
    cyc_t(4'b0001, 1'b1);
    cyc_t(4'b0001, 1'b0);
    cyc_t(4'b0001, 1'b1);
    cyc_t(4'b0000, 1'b1);
    chk("t5_release_gnt", gnt, 0);
    chk("t5_release_to", timeout, 0);
    cyc_t(4'b0000, 1'b0);
    cyc_t(4'b0001, 1'b1);
    chk("t5b_gnt", gnt, 4'b0001);
    cyc_t(4'b0001, 1'b1);
    cyc_t(4'b0001, 1'b1);
    chk("t5b_still_owned", gnt, 4'b0001);
    cyc_t(4'b0001, 1'b1);
    chk("t5b_expire_to", timeout, 1);
    chk("t5b_expire_gnt", gnt, 0);
    cyc_t(4'b0000, 1'b0);
    cyc_t(4'b0000, 1'b0);
    auto_tick = 1'b1;

    // 6. asynchronous reset mid-grant, pointer back to 0
    cyc(4'b0010);
    chk("t6_gnt", gnt, 4'b0010);
    cyc(4'b0010);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    chk("t6_async_gnt", gnt, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_id", gnt_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b1001);
    chk("t6_ptr0_winner", gnt_id, 0);
    cyc(4'b0000);
    cyc(4'b0000);
    cyc(4'b1000);
    chk("t6_gnt3", gnt, 4'b1000);
    cyc(4'b0000);
    cyc(4'b0000);
    cyc(4'b1001);
    chk("t6_after3_winner", gnt_id, 0);
    cyc(4'b0000);
    cyc(4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
